// File: rtl/neg_seq_n_pkg.sv
// Shared definitions for the multi-cycle two's-complement unit.
//   mode_e  : operation selector carried on the 2-bit mode port
//   state_e : sequencer state (IDLE waits for start, RUN walks the chunks)
//   idx_width(): width of the chunk index, never less than one bit
package neg_seq_n_pkg;

    typedef enum logic [1:0] {
        MODE_NEG     = 2'd0,
        MODE_ABS     = 2'd1,
        MODE_NOT     = 2'd2,
        MODE_NEG_SAT = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/neg_seq_n_chunk.sv
// One W-bit slice of the invert/increment datapath.
//   slice  : operand bits for this chunk
//   invert : 1 = use ~slice, 0 = use slice unchanged
//   cin    : carry into the lowest bit
//   sum    : (invert ? ~slice : slice) + cin, W bits
//   cout   : carry out of the top bit, feeds the next chunk
module neg_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] slice,
    input  logic         invert,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] x;
    logic         c;

    // Only a single carry is ever added, so each ripple stage is a
    // half adder: sum bit = x ^ c, carry = x & c.
    always_comb begin
        x   = invert ? ~slice : slice;
        c   = cin;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = x[i] ^ c;
            c      = x[i] & c;
        end
        cout = c;
    end

endmodule

// File: rtl/neg_seq_n.sv
// Multi-cycle two's-complement unit: NEG, ABS, NOT and saturating NEG,
// processed CHUNK bits per clock through one narrow invert/increment slice.
//   clk   : rising-edge clock
//   clr   : synchronous active-high reset, highest priority
//   start : request, only looked at while busy == 0
//   mode  : 00 NEG, 01 ABS, 10 NOT, 11 NEG_SAT, captured with start
//   rA    : operand, captured with start
//   rZ    : result, valid from done until the next accepted start
//   busy  : operation in progress
//   done  : one-cycle pulse, result valid
//   ovf   : operand was the most-negative value (not for NOT)
// Handshake: start is accepted on any rising edge where busy is low
// (including the done cycle); done pulses for exactly one cycle
// NCHUNK+1 cycles after acceptance, and there is no back-pressure.
module neg_seq_n
    import neg_seq_n_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] rA,
    output logic [WIDTH-1:0] rZ,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

    state_e           state, state_nxt;
    mode_e            mode_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             invert;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] rz_q;
    logic             busy_q, done_q, ovf_q;

    logic             accept, last;
    logic             inv_setup, cin_setup;
    int               base;
    logic [CHUNK-1:0] slice, sum;
    logic             cout;

    // Next state and start acceptance.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = (idx == IW'(NCHUNK - 1));
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-mode setup: ABS of a positive operand passes it through
    // unchanged (no invert, no increment).
    always_comb begin
        inv_setup = 1'b1;
        cin_setup = 1'b1;
        case (mode_e'(mode))
            MODE_NEG, MODE_NEG_SAT: begin
                inv_setup = 1'b1;
                cin_setup = 1'b1;
            end
            MODE_ABS: begin
                inv_setup = rA[WIDTH-1];
                cin_setup = rA[WIDTH-1];
            end
            MODE_NOT: begin
                inv_setup = 1'b1;
                cin_setup = 1'b0;
            end
            default: begin
                inv_setup = 1'b1;
                cin_setup = 1'b1;
            end
        endcase
    end

    always_comb begin
        base  = int'(idx) * CHUNK;
        slice = op[base +: CHUNK];
    end

    neg_chunk #(.W(CHUNK)) u_chunk (
        .slice (slice),
        .invert(invert),
        .cin   (carry),
        .sum   (sum),
        .cout  (cout)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= ST_IDLE;
            mode_q <= MODE_NEG;
            idx    <= '0;
            carry  <= 1'b0;
            invert <= 1'b0;
            op     <= '0;
            rz_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            if (accept) begin
                op     <= rA;
                mode_q <= mode_e'(mode);
                idx    <= '0;
                busy_q <= 1'b1;
                invert <= inv_setup;
                carry  <= cin_setup;
                ovf_q  <= (mode_e'(mode) != MODE_NOT) && (rA == MIN_NEG);
            end else if (state == ST_RUN) begin
                rz_q[base +: CHUNK] <= sum;
                carry               <= cout;
                idx                 <= idx + 1'b1;
                if (last) begin
                    idx    <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    // Saturation replaces the wrapped slice result; the
                    // final carry-out is simply dropped.
                    if (mode_q == MODE_NEG_SAT && ovf_q) begin
                        rz_q <= MAX_POS;
                    end
                end
            end
        end
    end

    assign rZ   = rz_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_neg_seq_n.sv
module tb_neg_seq_n;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             clr;
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] rA;
    logic [WIDTH-1:0] rZ;
    logic             busy, done, ovf;

    logic        start16, busy16, done16, ovf16;
    logic [1:0]  mode16;
    logic [15:0] rA16, rZ16;
    logic        start8, busy8, done8, ovf8;
    logic [1:0]  mode8;
    logic [7:0]  rA8, rZ8;

    neg_seq_n #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .clr(clr), .start(start), .mode(mode), .rA(rA),
        .rZ(rZ), .busy(busy), .done(done), .ovf(ovf)
    );

    neg_seq_n #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .clr(clr), .start(start16), .mode(mode16), .rA(rA16),
        .rZ(rZ16), .busy(busy16), .done(done16), .ovf(ovf16)
    );

    neg_seq_n #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .mode(mode8), .rA(rA8),
        .rZ(rZ8), .busy(busy8), .done(done8), .ovf(ovf8)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] exp_q[$];   // {ovf, rZ}
    logic [WIDTH:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain two's-complement arithmetic on the operand.
    function automatic logic [WIDTH:0] model(input logic [1:0] m, input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] mn, mx, neg, res;
        logic             o;
        mn = '0;
        mn[WIDTH-1] = 1'b1;
        mx  = ~mn;
        neg = '0 - a;
        o   = (m != 2'd2) && (a == mn);
        case (m)
            2'd0:    res = neg;
            2'd1:    res = a[WIDTH-1] ? neg : a;
            2'd2:    res = ~a;
            default: res = o ? mx : neg;
        endcase
        return {o, res};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!clr && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rz", 64'(rZ), 64'(mon_e[WIDTH-1:0]));
                chk("ovf", 64'(ovf), 64'(mon_e[WIDTH]));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge with busy low.
    task automatic issue(input logic [1:0] m, input logic [WIDTH-1:0] a, input bit push);
        start = 1'b1;
        mode  = m;
        rA    = a;
        if (push) exp_q.push_back(model(m, a));
    endtask

    // Issue one op and check busy in cycles 1..NCHUNK and done in NCHUNK+1.
    // Returns on the done cycle, so a following call starts in that cycle.
    task automatic timed_op(input logic [1:0] m, input logic [WIDTH-1:0] a);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 0;
        issue(m, a, 1);
        while (cyc < NCHUNK + 4 && !seen) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) seen = 1;
            else if (cyc <= NCHUNK) chk("busy_run", 64'(busy), 64'd1);
        end
        chk("done_latency", seen ? 64'(cyc) : 64'hFFFF, 64'(NCHUNK + 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic rand_op();
        logic [1:0]       m;
        logic [WIDTH-1:0] a;
        int sel;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wait_idle();
        m   = 2'($urandom_range(0, 3));
        sel = $urandom_range(0, 7);
        case (sel)
            0:       a = {1'b1, {(WIDTH-1){1'b0}}};
            1:       a = '0;
            2:       a = {1'b0, {(WIDTH-1){1'b1}}};
            3:       a = '1;
            default: a = $urandom;
        endcase
        issue(m, a, 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, d16, d8, n;
        logic [15:0] z16;
        logic [7:0]  z8;

        clr = 1'b1; start = 1'b0; mode = 2'd0; rA = '0;
        start16 = 1'b0; mode16 = 2'd0; rA16 = '0;
        start8 = 1'b0; mode8 = 2'd0; rA8 = '0;
        repeat (3) @(negedge clk);
        chk("reset_rz", 64'(rZ), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        clr = 1'b0;
        @(negedge clk);

        // Directed values, back to back (each next start lands in a done cycle).
        timed_op(2'd0, 32'd5);
        timed_op(2'd0, 32'h8000_0000);
        timed_op(2'd3, 32'h8000_0000);
        timed_op(2'd1, 32'hFFFF_FF9C);
        timed_op(2'd1, 32'h0000_002A);
        timed_op(2'd2, 32'h0F0F_00FF);
        timed_op(2'd0, 32'h0000_0100);
        timed_op(2'd0, 32'h0);
        timed_op(2'd1, 32'h0);
        timed_op(2'd2, 32'h0);
        timed_op(2'd3, 32'h0000_0001);
        @(negedge clk);

        // Starts in cycles 2-4 while busy, with operand/mode wiggling.
        issue(2'd0, 32'h1234_5678, 1);
        cyc = 0;
        while (cyc < 20 && !done) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc >= 2 && cyc <= 4) begin
                start = 1'b1;
                rA    = $urandom;
                mode  = 2'($urandom_range(0, 3));
            end
            if (cyc == 5) start = 1'b0;
        end
        start = 1'b0;
        chk("ignore_latency", 64'(cyc), 64'(NCHUNK + 1));
        @(negedge clk);

        // clr in cycle 2 of a RUN aborts it with no done pulse.
        issue(2'd0, 32'h8000_0000, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rz", 64'(rZ), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        clr = 1'b0;
        n = 0;
        repeat (NCHUNK + 2) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("abort_no_done", 64'(n), 64'd0);

        // Parameter overrides: NEG 5 on 16/4 and 8/8 instances.
        start16 = 1'b1; mode16 = 2'd0; rA16 = 16'd5;
        start8  = 1'b1; mode8  = 2'd0; rA8  = 8'd5;
        d16 = -1; d8 = -1; z16 = '0; z8 = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start16 = 1'b0;
            start8  = 1'b0;
            if (done16 && d16 < 0) begin d16 = c; z16 = rZ16; end
            if (done8 && d8 < 0) begin d8 = c; z8 = rZ8; end
        end
        chk("w16_done_cycle", 64'(d16), 64'd5);
        chk("w16_rz", 64'(z16), 64'hFFFB);
        chk("w8_done_cycle", 64'(d8), 64'd2);
        chk("w8_rz", 64'(z8), 64'hFB);

        // Randomized traffic.
        repeat (300) rand_op();

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
